lcg_stream_checker: RTL
=======================

# lcg_stream_checker

Receive-side checker for the 32-bit LCG stimulus stream our benches drive into designs under test. It regenerates the expected sequence from a seed (state ← state·0x41C64E6D + 0x3039 mod 2³², word = new state), compares each accepted word against it, and reports mismatches, counts and lock status. It sits at the consuming end of a stimulus channel, in benches or on-chip self-test, and is fully synthesizable.

## Interface
- `CNT_W`, default 16: width of the saturating mismatch counter.
- `STOP_ON_ERR`, default 0: when 1, the first mismatch freezes checking in FAIL.
- `clk` in 1: the single clock; all logic on posedge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: load `seed`, clear counters, begin checking.
- `seed` in 32: LCG seed, sampled only when `start`=1.
- `in_valid` in 1: `in_word` is valid this cycle.
- `in_word` in 32: received stream word.
- `in_ready` out 1: checker accepts words; 1 only in CHECK.
- `err_pulse` out 1: one-cycle pulse for each mismatched accepted word.
- `locked` out 1: last accepted word matched.
- `fail` out 1: sticky; set by the first mismatch.
- `mismatch_cnt` out CNT_W: saturating count of mismatches.
- `word_cnt` out 32: accepted words since `start`, wraps at 2³².
- `first_err_idx` out 32: `word_cnt` value of the first mismatch.

## Operation
- States: IDLE, CHECK, FAIL.
- IDLE: `in_ready`=0, so words are ignored. `start` → CHECK, with `exp_state`=seed.
- CHECK: a word is accepted when `in_valid`&&`in_ready`.
  - expected = lcg_next(`exp_state`). On accept, `exp_state` ← expected and `word_cnt`+1.
  - Match: `locked`=1.
  - Mismatch: `err_pulse`, `locked`=0, `mismatch_cnt`+1 (saturates at all-ones).
  - First mismatch since `start`: `fail`=1 and `first_err_idx`=`word_cnt` (pre-increment).
  - If `STOP_ON_ERR`=1, a mismatch goes to FAIL.
- FAIL: `in_ready`=0. All status outputs hold until `start` or reset.
- `start` in any state reloads `seed`, clears every counter and status, and enters CHECK. A word offered in the same cycle is discarded and not counted.
- Reset values (any time, including mid-stream): state IDLE; all outputs 0.

## Timing
- `in_ready` is a registered state decode and is valid from the cycle after the `start` edge.
- Latency is one cycle. A word accepted at edge N updates `err_pulse`, `locked`, the counters and `fail` at edge N. They are visible in cycle N+1.
- `err_pulse` is high for exactly one cycle per mismatched word. It can be high on back-to-back cycles.
- `word_cnt` wraps 0xFFFFFFFF→0 silently. `mismatch_cnt` does not wrap.
- Full throughput: one word per cycle with no bubbles.

## Configuration
- `LCG_CHK_RESYNC_EN` defined:
  - On a mismatch in CHECK, `exp_state` ← `in_word`, so the next expected word is lcg_next(`in_word`). The checker re-locks onto a stream that skipped or dropped words.
  - `mismatch_cnt` still increments.
  - Has no effect when `STOP_ON_ERR`=1, because FAIL is entered first.
- `LCG_CHK_RESYNC_EN` undefined: `exp_state` always advances to the expected value, whether the word matched or not.

## Structure
- Package `lcg_pkg`:
  - `LCG_MUL`=32'h41C64E6D and `LCG_INC`=32'h3039.
  - Function `lcg_next`.
  - State enum `chk_state_t`.
- Sub-module `lcg_step`: combinational 32-bit multiply-add, mod 2³². It is instantiated once for the expected-word path.

## Test plan
- Reset, then `start` with `seed`=0, then feed 0x00003039 and 0xD3DC167E. Expect `locked`=1, `mismatch_cnt`=0, `word_cnt`=2, `err_pulse` never high.
- Same seed, with the second word corrupted to 0xD3DC167F. Expect `err_pulse` for one cycle, `fail`=1, `first_err_idx`=1, `mismatch_cnt`=1. The third correct word gives `locked`=1 when the macro is undefined.
- With `LCG_CHK_RESYNC_EN` defined, `seed`=0: send 0x00003039, skip 0xD3DC167E, then send lcg_next(0xD3DC167E). Expect one error, then `locked`=1 on the following word, which is lcg_next of that third word.
- With `STOP_ON_ERR`=1, inject a mismatch. Expect `in_ready`=0 from the next cycle and counters frozen despite `in_valid`=1. A `start` clears the counters and re-enters CHECK.
- With `CNT_W`=2, send 5 consecutive bad words. Expect `mismatch_cnt`=3 (saturated) and `err_pulse` high for 5 cycles.
- Assert `rst_n`=0 mid-stream. Expect all outputs 0 immediately, asynchronously. After release, words are ignored until `start`.

Source files
------------

// File: rtl/lcg_pkg.sv
// Shared constants, state type and LCG step function for the LCG stream checker.
// Used by lcg_step and lcg_stream_checker.
package lcg_pkg;

  localparam logic [31:0] LCG_MUL = 32'h41C6_4E6D;
  localparam logic [31:0] LCG_INC = 32'h0000_3039;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FAIL  = 2'd2
  } chk_state_t;

  function automatic logic [31:0] lcg_next(
    input logic [31:0] s
  );
    return s * LCG_MUL + LCG_INC;
  endfunction

endpackage

// File: rtl/lcg_step.sv
// One LCG step: nxt = cur * LCG_MUL + LCG_INC, modulo 2^32.
// Purely combinational.
module lcg_step
  import lcg_pkg::*;
(
  input  logic [31:0] cur,
  output logic [31:0] nxt
);

  assign nxt = lcg_next(cur);

endmodule

// File: rtl/lcg_stream_checker.sv
// Receive-side checker for a 32-bit LCG stream.
// Optional build macro LCG_CHK_RESYNC_EN re-seeds the expected state from a bad word.
module lcg_stream_checker
  import lcg_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic             in_valid,
  input  logic [31:0]      in_word,
  output logic             in_ready,
  output logic             err_pulse,
  output logic             locked,
  output logic             fail,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [31:0]      word_cnt,
  output logic [31:0]      first_err_idx
);

  chk_state_t  state;
  logic [31:0] exp_state;
  logic [31:0] exp_word;
  logic [31:0] exp_nxt;
  logic        accept;
  logic        miss;

  lcg_step u_step (
    .cur (exp_state),
    .nxt (exp_word)
  );

  assign in_ready = (state == ST_CHECK);
  // start wins over a word offered in the same cycle
  assign accept   = in_valid && in_ready && !start;
  assign miss     = accept && (in_word != exp_word);

`ifdef LCG_CHK_RESYNC_EN
  assign exp_nxt = miss ? in_word : exp_word;
`else
  assign exp_nxt = exp_word;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      exp_state     <= '0;
      err_pulse     <= 1'b0;
      locked        <= 1'b0;
      fail          <= 1'b0;
      mismatch_cnt  <= '0;
      word_cnt      <= '0;
      first_err_idx <= '0;
    end else if (start) begin
      state         <= ST_CHECK;
      exp_state     <= seed;
      err_pulse     <= 1'b0;
      locked        <= 1'b0;
      fail          <= 1'b0;
      mismatch_cnt  <= '0;
      word_cnt      <= '0;
      first_err_idx <= '0;
    end else begin
      err_pulse <= miss;
      if (accept) begin
        exp_state <= exp_nxt;
        word_cnt  <= word_cnt + 32'd1;
        locked    <= !miss;
        if (miss) begin
          if (mismatch_cnt != '1)
            mismatch_cnt <= mismatch_cnt + 1'b1;
          if (!fail) begin
            fail          <= 1'b1;
            first_err_idx <= word_cnt;
          end
          if (STOP_ON_ERR)
            state <= ST_FAIL;
        end
      end
    end
  end

endmodule
